// File: rtl/store_data_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : store_pkg
// Purpose : Shared types and constants for the MEM-stage store packer:
//           store-size encodings, byte-enable patterns, the buffered store
//           entry record and the alignment check used at acceptance.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package store_pkg;

  // Store size as presented by the MEM stage (st_size).
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_e;

  // Byte-enable patterns; bit i enables byte lane i (little-endian).
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Entry address field is sized for the widest supported byte address;
  // narrower ADDR_W configurations zero-extend into it.
  localparam int ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;   // word-aligned address
    logic [31:0]             wdata;  // lane-replicated write data
    logic [3:0]              be;     // byte enables
  } store_entry_t;

  // A store is misaligned when its natural alignment is violated, or when
  // the size field carries the reserved encoding.
  function automatic logic is_misaligned(input store_size_e size,
                                         input logic [1:0]  addr_lo);
    logic result;
    result = 1'b1;
    case (size)
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = addr_lo[0];
      SZ_WORD: result = (addr_lo != 2'b00);
      SZ_RSVD: result = 1'b1;
      default: result = 1'b1;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_data_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : store_fifo
// Purpose : Synchronous FIFO of store_entry_t records for the store buffer.
//           The head entry is read straight from the storage registers, so
//           it is stable while the entry waits to be popped.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           push_i, entry_i   - enqueue request and record (ignored if full)
//           pop_i             - dequeue request (ignored if empty)
//           head_o            - oldest buffered record
//           full_o, empty_o   - occupancy flags
// Params  : DEPTH - number of entries, power of two, at least 2
// Revision: 1.0 - initial release
// ============================================================================
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  store_entry_t entry_i,
  input  logic         pop_i,
  output store_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  store_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_push;
  logic w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Guard against overflow/underflow so the caller cannot corrupt state.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  assign head_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // carries one extra bit to tell full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the memory-side outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_data_packer.sv
`default_nettype none
// ============================================================================
// Module  : store_data_packer
// Purpose : MEM-stage store path. Packs a register value into word-aligned,
//           lane-replicated write data plus byte enables (SB/SH/SW),
//           buffers packed stores in a small FIFO and hands them to data
//           memory over a valid/ready handshake. Misaligned or reserved-size
//           stores are consumed but dropped and reported via misalign and
//           bad_addr. The pipeline is stalled while the buffer is full.
// Ports   : clk, rst                   - clock, asynchronous active-high reset
//           st_valid/st_ready          - store handshake from MEM stage
//           st_addr, st_data, st_size  - byte address, rt value, size code
//           stall                      - st_valid && !st_ready
//           misalign, bad_addr         - error pulse and held fault address
//           mem_valid/mem_ready        - handshake toward data memory
//           mem_addr, mem_wdata, mem_be- head-of-buffer store
//           stores_done, misalign_cnt  - statistics (STORE_PACK_STATS_EN)
// Params  : DEPTH  - store-buffer entries (power of two, >= 2)
//           ADDR_W - byte-address width (2..32)
// Config  : STORE_PACK_STATS_EN - adds drain and misalign counters
// Revision: 1.0 - initial release
// ============================================================================
module store_data_packer
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] bad_addr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
`ifdef STORE_PACK_STATS_EN
  ,
  output logic [15:0]       stores_done,
  output logic [7:0]        misalign_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Acceptance and alignment
  // --------------------------------------------------------------------------
  store_size_e  w_size;
  logic         w_accept;
  logic         w_bad;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [31:0]  w_wdata;
  logic [3:0]   w_be;
  store_entry_t w_entry;
  store_entry_t w_head;

  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

  assign w_size   = store_size_e'(st_size);
  assign w_accept = st_valid && st_ready;
  assign w_bad    = is_misaligned(w_size, st_addr[1:0]);

  // Misaligned stores complete the handshake but never reach the buffer.
  assign w_push   = w_accept && !w_bad;

  // --------------------------------------------------------------------------
  // Packing: replicate the narrow datum across every lane it could occupy,
  // and let the byte enables select the lane(s) actually written.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wdata = st_data;
    w_be    = BE_WORD;
    case (w_size)
      SZ_BYTE: begin
        w_wdata = {4{st_data[7:0]}};
        w_be    = BE_BYTE0 << st_addr[1:0];
      end
      SZ_HALF: begin
        w_wdata = {2{st_data[15:0]}};
        w_be    = st_addr[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      SZ_WORD: begin
        w_wdata = st_data;
        w_be    = BE_WORD;
      end
      default: begin
        // Reserved size never enqueues; the packed value is irrelevant.
        w_wdata = st_data;
        w_be    = BE_WORD;
      end
    endcase
  end

  always_comb begin
    w_entry       = '0;
    w_entry.addr  = ENTRY_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00});
    w_entry.wdata = w_wdata;
    w_entry.be    = w_be;
  end

  // --------------------------------------------------------------------------
  // Store buffer
  // --------------------------------------------------------------------------
  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .entry_i (w_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // No pass-through when full: a drain in the same cycle frees the slot
  // only for the following cycle.
  assign st_ready  = !w_full;
  assign stall     = st_valid && !st_ready;

  assign mem_valid = !w_empty;
  assign w_pop     = mem_valid && mem_ready;
  assign mem_addr  = w_head.addr[ADDR_W-1:0];
  assign mem_wdata = w_head.wdata;
  assign mem_be    = w_head.be;

  // --------------------------------------------------------------------------
  // Misalignment reporting: a pulse per bad store, address held until the
  // next bad store.
  // --------------------------------------------------------------------------
  always_comb begin
    misalign_d = w_accept && w_bad;
    bad_addr_d = bad_addr_q;
    if (w_accept && w_bad) begin
      bad_addr_d = st_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef STORE_PACK_STATS_EN
  logic [15:0] stores_done_q, stores_done_d;
  logic [7:0]  misalign_cnt_q, misalign_cnt_d;

  always_comb begin
    stores_done_d  = stores_done_q;
    misalign_cnt_d = misalign_cnt_q;
    if (w_pop) begin
      // Wraps from 0xFFFF to 0.
      stores_done_d = stores_done_q + 16'd1;
    end
    if (w_accept && w_bad && (misalign_cnt_q != 8'hFF)) begin
      misalign_cnt_d = misalign_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stores_done_q  <= '0;
      misalign_cnt_q <= '0;
    end else begin
      stores_done_q  <= stores_done_d;
      misalign_cnt_q <= misalign_cnt_d;
    end
  end

  assign stores_done  = stores_done_q;
  assign misalign_cnt = misalign_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_data_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_data_packer
// Purpose : Self-checking bench for store_data_packer: a vector table for
//           packing/misalignment, hand-written sequences for back-to-back
//           misaligned stores, back-pressure, async reset and streaming.
//           Expected drains are queued at drive time and compared by a
//           monitor as memory accepts them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_store_data_packer;
  import store_pkg::*;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              stall;
  logic              misalign;
  logic [ADDR_W-1:0] bad_addr;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
`ifdef STORE_PACK_STATS_EN
  logic [15:0]       stores_done;
  logic [7:0]        misalign_cnt;
`endif

  store_data_packer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .stall     (stall),
    .misalign  (misalign),
    .bad_addr  (bad_addr),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
`ifdef STORE_PACK_STATS_EN
    ,
    .stores_done  (stores_done),
    .misalign_cnt (misalign_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    bit          mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  exp_t sb_q [$];
  exp_t mon_e;
  int   checks      = 0;
  int   failures    = 0;
  int   drains_seen = 0;
  int   mis_seen    = 0;
  logic [31:0] last_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted memory write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      drains_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%08h expected no write at %0t", mem_addr, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("drain_addr", mem_addr, mon_e.addr);
        check("drain_wdata", mem_wdata, mon_e.wdata);
        check("drain_be", {28'd0, mem_be}, {28'd0, mon_e.be});
      end
    end
  end

  // Present a store; the expected drain is queued now if it should enqueue.
  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input bit exp_push, input logic [31:0] ea,
                             input logic [31:0] ew, input logic [3:0] eb);
    exp_t e;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    if (exp_push) begin
      e.addr  = ea;
      e.wdata = ew;
      e.be    = eb;
      sb_q.push_back(e);
    end
  endtask

  // Hold the store until accepted; returns 1 time unit after the accepting edge.
  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (st_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    st_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got st_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) begin
      @(negedge clk);
    end
    check("drain_complete", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = 2'b00;
    mem_ready = 1'b1;
    last_bad  = '0;

    //                 addr        data          size   mis  exp_addr      exp_wdata     be
    vecs[0] = '{32'h0000_1003, 32'h1234_56AB, 2'b00, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{32'h0000_2002, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2] = '{32'h0000_2000, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011};
    vecs[3] = '{32'h0000_3001, 32'h1111_1111, 2'b10, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[4] = '{32'h0000_3004, 32'h0000_0022, 2'b11, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[5] = '{32'h0000_4000, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111};
    vecs[6] = '{32'h0000_4001, 32'h0000_00A5, 2'b00, 1'b0, 32'h0000_4000, 32'hA5A5_A5A5, 4'b0010};
    vecs[7] = '{32'h0000_4003, 32'h0000_5678, 2'b01, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[8] = '{32'h0000_5006, 32'h0000_1234, 2'b10, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[9] = '{32'h0000_7002, 32'h0000_00C3, 2'b00, 1'b0, 32'h0000_7000, 32'hC3C3_C3C3, 4'b0100};

    // Reset state
    #12;
    check("rst_st_ready", st_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_misalign", misalign, 0);
    check("rst_bad_addr", bad_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", {28'd0, mem_be}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Vector table, memory always ready
    for (int i = 0; i < NV; i++) begin
      start_store(vecs[i].addr, vecs[i].data, vecs[i].size, !vecs[i].mis,
                  vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_be);
      wait_accept();
      @(negedge clk);
      if (vecs[i].mis) begin
        last_bad = vecs[i].addr;
        mis_seen++;
      end
      check("vec_misalign", misalign, {31'd0, vecs[i].mis});
      check("vec_bad_addr", bad_addr, last_bad);
      check("vec_mem_valid", mem_valid, {31'd0, !vecs[i].mis});
      @(negedge clk);
      check("vec_misalign_pulse_end", misalign, 0);
      @(posedge clk);
      #1;
    end
    check("table_drained", sb_q.size(), 0);

    // Back-to-back misaligned stores give consecutive pulses
    start_store(32'h0000_6001, 32'h0, 2'b10, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1 st_addr = 32'h0000_6002;
    @(negedge clk);
    check("b2b_misalign_1", misalign, 1);
    check("b2b_bad_addr_1", bad_addr, 32'h0000_6001);
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    check("b2b_misalign_2", misalign, 1);
    check("b2b_bad_addr_2", bad_addr, 32'h0000_6002);
    @(negedge clk);
    check("b2b_misalign_end", misalign, 0);
    check("b2b_mem_valid", mem_valid, 0);
    mis_seen += 2;
    @(posedge clk);
    #1;

    // Back-pressure: fill the buffer, then release memory
    mem_ready = 1'b0;
    start_store(32'h10, 32'hAAAA_0010, 2'b10, 1'b1, 32'h10, 32'hAAAA_0010, 4'hF);
    wait_accept();
    start_store(32'h14, 32'hAAAA_0014, 2'b10, 1'b1, 32'h14, 32'hAAAA_0014, 4'hF);
    wait_accept();
    start_store(32'h18, 32'hAAAA_0018, 2'b10, 1'b1, 32'h18, 32'hAAAA_0018, 4'hF);
    @(negedge clk);
    check("bp_st_ready", st_ready, 0);
    check("bp_stall", stall, 1);
    check("bp_mem_valid", mem_valid, 1);
    check("bp_head_addr", mem_addr, 32'h10);
    @(posedge clk);
    #1;
    check("bp_head_stable", mem_addr, 32'h10);
    check("bp_still_full", st_ready, 0);
    mem_ready = 1'b1;
    wait_accept();
    wait_drain();

`ifdef STORE_PACK_STATS_EN
    check("stats_stores_done", {16'd0, stores_done}, drains_seen);
    check("stats_misalign_cnt", {24'd0, misalign_cnt}, mis_seen);
`endif

    // Async reset with two buffered entries
    mem_ready = 1'b0;
    start_store(32'h40, 32'h0000_0040, 2'b10, 1'b1, 32'h40, 32'h0000_0040, 4'hF);
    wait_accept();
    start_store(32'h44, 32'h0000_0044, 2'b10, 1'b1, 32'h44, 32'h0000_0044, 4'hF);
    wait_accept();
    @(negedge clk);
    check("pre_rst_mem_valid", mem_valid, 1);
    check("pre_rst_full", st_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_valid", mem_valid, 0);
    check("async_rst_st_ready", st_ready, 1);
    check("async_rst_mem_be", {28'd0, mem_be}, 0);
    sb_q.delete();
    drains_seen = 0;
    mis_seen    = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_no_stale", mem_valid, 0);
    @(posedge clk);
    #1;

    // Streaming: one push and one pop per cycle, never stalling
    for (int i = 0; i < 8; i++) begin
      start_store(32'h100 + 32'(4 * i), 32'h5A00_0000 + 32'(i), 2'b10, 1'b1,
                  32'h100 + 32'(4 * i), 32'h5A00_0000 + 32'(i), 4'hF);
      @(negedge clk);
      check("stream_st_ready", st_ready, 1);
      check("stream_stall", stall, 0);
      if (i > 0) begin
        check("stream_mem_valid", mem_valid, 1);
      end
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    wait_drain();

`ifdef STORE_PACK_STATS_EN
    check("stats_stream_done", {16'd0, stores_done}, drains_seen);
    check("stats_stream_mis", {24'd0, misalign_cnt}, mis_seen);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
